// File: rtl/cache_ctrl.sv
// Direct-mapped, read-only cache controller: 8-bit word address, 64-bit lines of
// four 16-bit words, single outstanding line fill, hit/miss statistics.
module cache_ctrl #(
  parameter int unsigned LINES = 8,
  parameter int unsigned TAG_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [7:0]  cpu_addr,
  output logic        cpu_busy,
  output logic        cpu_ready,
  output logic [15:0] cpu_data,
  output logic        mem_rd_en,
  output logic [5:0]  mem_addr,
  input  logic        mem_data_rdy,
  input  logic [63:0] mem_data,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int unsigned IDX_W = $clog2(LINES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REQ    = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, state_d;

  logic [7:0]       addr_q;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [63:0]      data_mem [LINES];

  // Lookup port: in IDLE it probes the incoming address so the hit response can be
  // registered for the LOOKUP cycle; otherwise it probes the latched address.
  logic [7:0]       lk_addr;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [63:0]      lk_data;
  logic             lk_hit;
  logic [15:0]      lk_word;

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [15:0]      fill_word;

  logic             ready_d;
  logic [15:0]      data_d;
  logic             hit_inc;
  logic             miss_inc;
  logic             fill_we;

  // Cache array read and hit detection
  always_comb begin
    lk_addr = (state == IDLE) ? cpu_addr : addr_q;
    lk_idx  = lk_addr[2 +: IDX_W];
    lk_tag  = TAG_W'(lk_addr[7:2+IDX_W]);
    lk_data = data_mem[lk_idx];
    lk_hit  = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    lk_word = lk_data[{lk_addr[1:0], 4'b0000} +: 16];
  end

  // Fill-side address split and word select from the incoming memory line
  always_comb begin
    wr_idx    = addr_q[2 +: IDX_W];
    wr_tag    = TAG_W'(addr_q[7:2+IDX_W]);
    fill_word = mem_data[{addr_q[1:0], 4'b0000} +: 16];
  end

  // Next-state and next-output decode
  always_comb begin
    state_d  = state;
    ready_d  = 1'b0;
    data_d   = 16'h0000;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    fill_we  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_d = LOOKUP;
          if (lk_hit) begin
            ready_d = 1'b1;
            data_d  = lk_word;
          end
        end
      end
      LOOKUP: begin
        if (lk_hit) begin
          state_d = IDLE;
          hit_inc = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (mem_data_rdy) begin
          state_d = RESP;
          fill_we = 1'b1;
          ready_d = 1'b1;
          data_d  = fill_word;
        end
      end
      RESP: begin
        state_d  = IDLE;
        miss_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered outputs, valid bits and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 8'h00;
      valid     <= '0;
      cpu_ready <= 1'b0;
      cpu_data  <= 16'h0000;
      cpu_busy  <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= 6'h00;
      hit_cnt   <= 16'h0000;
      miss_cnt  <= 16'h0000;
    end else begin
      state     <= state_d;
      cpu_ready <= ready_d;
      cpu_data  <= data_d;
      cpu_busy  <= (state_d != IDLE);
      mem_rd_en <= (state_d == REQ);
      if (state == IDLE && cpu_req) addr_q <= cpu_addr;
      // mem_addr only moves when a new fill starts, so it stays stable past the fill
      if (state_d == REQ) mem_addr <= addr_q[7:2];
      if (fill_we) valid[wr_idx] <= 1'b1;
      if (hit_inc) hit_cnt <= hit_cnt + 16'd1;
      if (miss_inc) miss_cnt <= miss_cnt + 16'd1;
    end
  end

  // Tag and data arrays; no reset, qualified by the valid bits
  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl (LINES=8, TAG_W=3).
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [7:0]  cpu_addr;
  logic        cpu_busy;
  logic        cpu_ready;
  logic [15:0] cpu_data;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic        mem_data_rdy;
  logic [63:0] mem_data;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks;
  int errors;

  localparam logic [63:0] LINE_A = 64'h4444_3333_2222_1111;
  localparam logic [63:0] LINE_B = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] LINE_C = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] LINE_D = 64'h7777_6666_5555_4444;
  localparam logic [63:0] JUNK   = 64'hDEAD_BEEF_DEAD_BEEF;

  cache_ctrl #(.LINES(8), .TAG_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_busy     (cpu_busy),
    .cpu_ready    (cpu_ready),
    .cpu_data     (cpu_data),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_data_rdy (mem_data_rdy),
    .mem_data     (mem_data),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge, act as a memory with 'lat' cycles from the
  // sampled mem_rd_en to mem_data_rdy, and check latency, data and side effects.
  // With noise set, cpu_req pulses during WAIT and a junk mem_data_rdy lands in REQ.
  task automatic run_req(input string tag, input logic [7:0] addr, input logic [63:0] line,
                         input int lat, input bit exp_hit, input logic [15:0] exp_data,
                         input bit noise, input int tail);
    int rdy_at, ready_k, rd_cnt, ready_cnt, bad_data, bad_busy, bad_addr;
    logic [15:0] got_data;
    bit exp_busy;
    rdy_at = -1; ready_k = -1; rd_cnt = 0; ready_cnt = 0;
    bad_data = 0; bad_busy = 0; bad_addr = 0; got_data = 16'h0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      cpu_req      = noise && (k == 3 || k == 4);
      cpu_addr     = cpu_req ? 8'h05 : addr;
      mem_data_rdy = 1'b0;
      mem_data     = 64'h0;
      if (mem_rd_en) begin
        rd_cnt++;
        rdy_at = k + lat;
      end
      if (rd_cnt > 0 && ready_k < 0 && mem_addr !== addr[7:2]) bad_addr++;
      exp_busy = (ready_k < 0);
      if (cpu_ready) begin
        ready_cnt++;
        if (ready_k < 0) begin
          ready_k  = k;
          got_data = cpu_data;
        end
      end else if (cpu_data !== 16'h0) begin
        bad_data++;
      end
      if (cpu_busy !== exp_busy) bad_busy++;
      if (k == rdy_at) begin
        mem_data_rdy = 1'b1;
        mem_data     = line;
      end
      if (noise && k == 2) begin
        mem_data_rdy = 1'b1;
        mem_data     = JUNK;
      end
      if (ready_k >= 0 && k >= ready_k + tail) break;
    end
    cpu_req      = 1'b0;
    mem_data_rdy = 1'b0;
    check({tag, "_ready_cycle"}, 64'(ready_k), 64'(exp_hit ? 1 : lat + 3));
    check({tag, "_data"}, 64'(got_data), 64'(exp_data));
    check({tag, "_rd_en_count"}, 64'(rd_cnt), 64'(exp_hit ? 0 : 1));
    check({tag, "_ready_count"}, 64'(ready_cnt), 64'd1);
    check({tag, "_mem_addr_hold"}, 64'(bad_addr), 64'd0);
    check({tag, "_data_zero_idle"}, 64'(bad_data), 64'd0);
    check({tag, "_busy"}, 64'(bad_busy), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = 8'h00;
    mem_data_rdy = 1'b0; mem_data = 64'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(cpu_ready), 64'd0);
    check("rst_busy", 64'(cpu_busy), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_data", 64'(cpu_data), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    rst = 1'b0;

    // Cold miss then hit in the same line
    run_req("cold_miss", 8'h25, LINE_A, 5, 1'b0, 16'h2222, 1'b0, 2);
    check("cold_miss_cnt", 64'(miss_cnt), 64'd1);
    run_req("hit", 8'h27, LINE_A, 5, 1'b1, 16'h4444, 1'b0, 2);
    check("hit_cnt1", 64'(hit_cnt), 64'd1);

    // Back-to-back hits with one idle cycle between responses
    run_req("b2b_a", 8'h24, LINE_A, 5, 1'b1, 16'h1111, 1'b0, 0);
    run_req("b2b_b", 8'h26, LINE_A, 5, 1'b1, 16'h3333, 1'b0, 2);
    check("b2b_hit_cnt", 64'(hit_cnt), 64'd3);

    // Conflict on index 1: line 0x11 evicts line 0x09, which then misses again
    run_req("conflict", 8'h45, LINE_B, 3, 1'b0, 16'hCCCC, 1'b0, 2);
    run_req("refetch", 8'h25, LINE_A, 5, 1'b0, 16'h2222, 1'b0, 2);
    check("conflict_miss_cnt", 64'(miss_cnt), 64'd3);

    // Busy requests and a junk mem_data_rdy in REQ are ignored
    run_req("noise", 8'h31, LINE_C, 4, 1'b0, 16'h89AB, 1'b1, 2);
    @(negedge clk);
    mem_data_rdy = 1'b1;
    mem_data     = JUNK;
    @(negedge clk);
    mem_data_rdy = 1'b0;
    mem_data     = 64'h0;
    check("idle_rdy_busy", 64'(cpu_busy), 64'd0);
    run_req("after_noise", 8'h33, LINE_C, 4, 1'b1, 16'h0123, 1'b0, 2);
    run_req("keep_idx1", 8'h25, LINE_A, 4, 1'b1, 16'h2222, 1'b0, 2);
    check("noise_hit_cnt", 64'(hit_cnt), 64'd5);
    check("noise_miss_cnt", 64'(miss_cnt), 64'd4);

    // Reset while waiting for memory
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 8'h61;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    check("rm_rd_en", 64'(mem_rd_en), 64'd1);
    @(negedge clk);
    check("rm_in_wait_busy", 64'(cpu_busy), 64'd1);
    rst = 1'b1; mem_data_rdy = 1'b1; mem_data = JUNK;
    @(negedge clk);
    rst = 1'b0; mem_data_rdy = 1'b0; mem_data = 64'h0;
    check("rm_busy", 64'(cpu_busy), 64'd0);
    check("rm_ready", 64'(cpu_ready), 64'd0);
    check("rm_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rm_miss_cnt", 64'(miss_cnt), 64'd0);
    @(negedge clk);
    check("rm_ready_late", 64'(cpu_ready), 64'd0);
    run_req("rm_retry", 8'h61, LINE_D, 5, 1'b0, 16'h5555, 1'b0, 2);
    check("rm_retry_miss_cnt", 64'(miss_cnt), 64'd1);

    // Hit counter wraps modulo 2^16
    @(negedge clk);
    force dut.hit_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt;
    run_req("wrap", 8'h63, LINE_D, 5, 1'b1, 16'h7777, 1'b0, 2);
    check("wrap_hit_cnt", 64'(hit_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter LINES, default 8, number of direct-mapped cache lines; SHALL be a power of two from 2 to 64.
REQ-002 Parameter TAG_W, default 3, tag width; SHALL equal 6 - log2(LINES).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  CPU read request; sampled only in IDLE.
REQ-006 cpu_addr  in  8  word address: [7:2] = line address, [1:0] = 16-bit word select.
REQ-007 cpu_busy  out  1  high in every state except IDLE.
REQ-008 cpu_ready  out  1  one-cycle pulse; cpu_data is valid in that cycle.
REQ-009 cpu_data  out  16  requested word.
REQ-010 mem_rd_en  out  1  one-cycle line-read request to off-chip memory.
REQ-011 mem_addr  out  6  line address to memory.
REQ-012 mem_data_rdy  in  1  one-cycle pulse from memory; line valid on mem_data.
REQ-013 mem_data  in  64  memory line; word k = bits [16k+15:16k].
REQ-014 hit_cnt, miss_cnt  out  16 each  completed-request statistics.

Function
REQ-015 Storage: LINES entries of {valid, tag[TAG_W], data[64]}.
REQ-016 Address split: index = line address [log2(LINES)-1:0]; tag = line address [5:log2(LINES)].
REQ-017 FSM states SHALL be IDLE, LOOKUP, REQ, WAIT and RESP.
REQ-018 IDLE: when cpu_req=1, the FSM SHALL latch cpu_addr into addr_q and go to LOOKUP; otherwise it stays in IDLE.
REQ-019 LOOKUP: a hit (valid set and tag equal) SHALL assert cpu_ready for that one cycle with the selected word on cpu_data, increment hit_cnt, and go to IDLE.
REQ-020 LOOKUP: a miss SHALL go to REQ without asserting cpu_ready.
REQ-021 REQ: mem_rd_en=1 for exactly one cycle with mem_addr=addr_q[7:2], then go to WAIT.
REQ-022 mem_addr SHALL hold addr_q[7:2] from REQ until the cycle after mem_data_rdy; the memory samples the address late.
REQ-023 WAIT: on mem_data_rdy=1, the FSM SHALL write mem_data into the indexed entry, set valid, write the tag, latch mem_data into fill_q, and go to RESP.
REQ-024 WAIT has no timeout; the FSM SHALL stay in WAIT until mem_data_rdy is seen.
REQ-025 RESP: cpu_ready=1 for one cycle with cpu_data = word addr_q[1:0] of fill_q, increment miss_cnt, go to IDLE.
REQ-026 Latency (T0 = edge that samples cpu_req):
  - hit: cpu_ready at T1.
  - miss: mem_rd_en at T2; with 5-cycle memory, mem_data_rdy at T7 and cpu_ready at T8.
REQ-027 mem_data_rdy outside WAIT SHALL be ignored and SHALL NOT modify storage.
REQ-028 cpu_req while cpu_busy=1 SHALL be ignored; the requester must hold or re-issue it.
REQ-029 A miss SHALL replace the indexed line unconditionally; the arrays are read-only, so no write-back.
REQ-030 Back-to-back requests: a request in IDLE the cycle after cpu_ready SHALL be accepted, giving one idle cycle between responses.
REQ-031 hit_cnt and miss_cnt SHALL wrap modulo 2^16.
REQ-032 cpu_data SHALL be 0 whenever cpu_ready=0.
REQ-033 mem_rd_en SHALL never be asserted twice for the same miss.

Reset
REQ-034 With rst=1 at a clock edge:
  - state = IDLE;
  - all valid bits = 0;
  - hit_cnt = miss_cnt = 0;
  - cpu_ready = cpu_busy = mem_rd_en = 0;
  - cpu_data = 0, mem_addr = 0.
REQ-035 Tag and data arrays need no reset.
REQ-036 Reset during WAIT SHALL abandon the miss, with no line written and no cpu_ready; the memory shares rst, so no stale mem_data_rdy is expected.

Verification
REQ-037 Cold miss: after reset, cpu_req with addr=0x25:
  - mem_rd_en at T2 with mem_addr=0x09;
  - mem_data=0x4444_3333_2222_1111 at T7;
  - cpu_ready at T8 with cpu_data=0x2222;
  - miss_cnt=1.
REQ-038 Hit: then addr=0x27 -> cpu_ready at T1 with cpu_data=0x4444, no mem_rd_en, hit_cnt=1.
REQ-039 Conflict (LINES=8): addr=0x25, then 0x45 (line 0x11, same index 1) -> second request misses and refetches; a later 0x25 misses again.
REQ-040 Busy/ignore: cpu_req pulses and a spurious mem_data_rdy during REQ/WAIT -> no extra mem_rd_en, storage unchanged, exactly one cpu_ready.
REQ-041 Reset mid-miss: rst during WAIT -> IDLE next cycle, cpu_busy=0, no cpu_ready, counters 0; a following request to the same address misses.
REQ-042 Counter wrap: force hit_cnt=0xFFFF, one hit -> hit_cnt=0x0000.
